// File: rtl/cfir_pkg.sv
// Shared types and helpers for the transposed-form complex FIR.
// Default-width complex types for users that keep the standard 16-bit datapath.
package cfir_pkg;

  localparam int DEF_SAMPLE_W = 16;
  localparam int DEF_COEF_W   = 16;
  localparam int DEF_ACC_W    = 36;

  typedef struct packed {
    logic signed [DEF_SAMPLE_W-1:0] im;
    logic signed [DEF_SAMPLE_W-1:0] re;
  } cplx_sample_t;

  typedef struct packed {
    logic signed [DEF_COEF_W-1:0] im;
    logic signed [DEF_COEF_W-1:0] re;
  } cplx_coef_t;

  typedef struct packed {
    logic signed [DEF_ACC_W-1:0] im;
    logic signed [DEF_ACC_W-1:0] re;
  } cplx_acc_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Symmetric clamp to +/-(2^(w-1)-1); the most negative code is never produced.
  function automatic logic signed [63:0] sat_sym(input logic signed [63:0] v, input int w);
    logic signed [63:0] lim;
    lim = (64'sd1 <<< (w - 1)) - 64'sd1;
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

endpackage

// File: rtl/cfir_tap.sv
// One transposed-form tap: coefficient register, complex multiplier and
// accumulator register adding the product to the partial sum from the next tap.
module cfir_tap
  import cfir_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int COEF_W   = 16,
  parameter int ACC_W    = 36
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  upd_en,
  input  logic                  coef_we,
  input  logic [2*COEF_W-1:0]   coef_in,
  input  logic [2*SAMPLE_W-1:0] x_in,
  input  logic [2*ACC_W-1:0]    a_in,
  output logic [2*ACC_W-1:0]    a_out
);

  localparam int PROD_W = SAMPLE_W + COEF_W + 1;

  logic signed [COEF_W-1:0]   h_re_reg, h_im_reg;
  logic signed [ACC_W-1:0]    a_re_reg, a_im_reg;
  logic signed [SAMPLE_W-1:0] x_re, x_im;
  logic signed [ACC_W-1:0]    a_in_re, a_in_im;
  logic signed [PROD_W-1:0]   p_re, p_im;

  assign x_re    = x_in[SAMPLE_W-1:0];
  assign x_im    = x_in[2*SAMPLE_W-1:SAMPLE_W];
  assign a_in_re = a_in[ACC_W-1:0];
  assign a_in_im = a_in[2*ACC_W-1:ACC_W];

  always_comb begin
    p_re = PROD_W'(x_re) * PROD_W'(h_re_reg) - PROD_W'(x_im) * PROD_W'(h_im_reg);
    p_im = PROD_W'(x_re) * PROD_W'(h_im_reg) + PROD_W'(x_im) * PROD_W'(h_re_reg);
  end

  // Coefficients survive clear; the update reads the pre-write coefficient.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_re_reg <= '0;
      h_im_reg <= '0;
      a_re_reg <= '0;
      a_im_reg <= '0;
    end else begin
      if (coef_we) {h_im_reg, h_re_reg} <= coef_in;
      if (clear) begin
        a_re_reg <= '0;
        a_im_reg <= '0;
      end else if (upd_en) begin
        a_re_reg <= ACC_W'(p_re) + a_in_re;
        a_im_reg <= ACC_W'(p_im) + a_in_im;
      end
    end
  end

  assign a_out = {a_im_reg, a_re_reg};

endmodule

// File: rtl/cfir_transposed.sv
// Parametrised complex transposed-form FIR with AXI-Stream in/out and a
// coefficient write port. Define CFIR_ROUND_EN for round-half-up output scaling.
module cfir_transposed
  import cfir_pkg::*;
#(
  parameter int NUM_TAPS  = 8,
  parameter int SAMPLE_W  = 16,
  parameter int COEF_W    = 16,
  parameter int OUT_SHIFT = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [2*SAMPLE_W-1:0]       s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [2*SAMPLE_W-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  input  logic                        coef_wr_en,
  input  logic [((clog2(NUM_TAPS) < 1) ? 1 : clog2(NUM_TAPS))-1:0] coef_addr,
  input  logic [2*COEF_W-1:0]         coef_data,
  input  logic                        clear
);

  localparam int TAP_LOG = clog2(NUM_TAPS);
  localparam int ADDR_W  = (TAP_LOG < 1) ? 1 : TAP_LOG;
  localparam int ACC_W   = SAMPLE_W + COEF_W + 1 + TAP_LOG;
  localparam int EXT_W   = ACC_W + 1;
`ifdef CFIR_ROUND_EN
  localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam logic signed [EXT_W-1:0] ROUND_BIAS =
    (OUT_SHIFT > 0) ? (EXT_W'(1) <<< RND_SH) : EXT_W'(0);
`endif

  logic                  en;
  logic                  v1_reg, v2_reg, m_valid_reg;
  logic [2*SAMPLE_W-1:0] x_reg, m_data_reg;
  logic [2*ACC_W-1:0]    chain [NUM_TAPS+1];
  logic signed [ACC_W-1:0] a0_re, a0_im;

  assign en            = !m_valid_reg || m_axis_tready;
  assign s_axis_tready = en && !rst;
  assign m_axis_tvalid = m_valid_reg;
  assign m_axis_tdata  = m_data_reg;

  assign chain[NUM_TAPS] = '0;

  generate
    for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
      cfir_tap #(
        .SAMPLE_W(SAMPLE_W),
        .COEF_W  (COEF_W),
        .ACC_W   (ACC_W)
      ) u_tap (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .upd_en (en && v1_reg),
        .coef_we(coef_wr_en && (coef_addr == ADDR_W'(gi))),
        .coef_in(coef_data),
        .x_in   (x_reg),
        .a_in   (chain[gi+1]),
        .a_out  (chain[gi])
      );
    end
  endgenerate

  assign a0_re = chain[0][ACC_W-1:0];
  assign a0_im = chain[0][2*ACC_W-1:ACC_W];

  // Scale in one extra bit so the rounding bias cannot overflow, then clamp.
  function automatic logic [SAMPLE_W-1:0] to_out(input logic signed [ACC_W-1:0] a);
    logic signed [EXT_W-1:0] ext;
    ext = EXT_W'(a);
`ifdef CFIR_ROUND_EN
    ext = ext + ROUND_BIAS;
`endif
    ext = ext >>> OUT_SHIFT;
    return SAMPLE_W'(sat_sym(64'(ext), SAMPLE_W));
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg       <= '0;
      v1_reg      <= 1'b0;
      v2_reg      <= 1'b0;
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
    end else if (clear) begin
      x_reg       <= '0;
      v1_reg      <= 1'b0;
      v2_reg      <= 1'b0;
      m_valid_reg <= 1'b0;
    end else if (en) begin
      v1_reg      <= s_axis_tvalid;
      if (s_axis_tvalid) x_reg <= s_axis_tdata;
      v2_reg      <= v1_reg;
      m_valid_reg <= v2_reg;
      if (v2_reg) m_data_reg <= {to_out(a0_im), to_out(a0_re)};
    end
  end

endmodule

// File: tb/tb_cfir_transposed.sv
// Self-checking bench: two filter instances (OUT_SHIFT 0 and 1) driven in lockstep,
// checked against fixed expectations and a direct-convolution reference model.
module tb_cfir_transposed;

  localparam int NT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready0, s_tready1;
  logic [31:0] m_tdata0, m_tdata1;
  logic        m_tvalid0, m_tvalid1;
  logic        m_tready = 1'b1;
  logic        coef_wr_en = 1'b0;
  logic [1:0]  coef_addr = '0;
  logic [31:0] coef_data = '0;
  logic        clear = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  longint      h_re[NT];
  longint      h_im[NT];
  longint      hist_re[$];
  longint      hist_im[$];
  logic [31:0] exp0_q[$];
  logic [31:0] exp1_q[$];

  logic [31:0] imp_out[8];
  int          imp_lat[8];
  int          imp_n;

  always #5 clk = ~clk;

  cfir_transposed #(.NUM_TAPS(NT), .SAMPLE_W(16), .COEF_W(16), .OUT_SHIFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready0), .m_axis_tdata(m_tdata0), .m_axis_tvalid(m_tvalid0),
    .m_axis_tready(m_tready), .coef_wr_en(coef_wr_en), .coef_addr(coef_addr),
    .coef_data(coef_data), .clear(clear)
  );

  cfir_transposed #(.NUM_TAPS(NT), .SAMPLE_W(16), .COEF_W(16), .OUT_SHIFT(1)) u_dut1 (
    .clk(clk), .rst(rst), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready1), .m_axis_tdata(m_tdata1), .m_axis_tvalid(m_tvalid1),
    .m_axis_tready(m_tready), .coef_wr_en(coef_wr_en), .coef_addr(coef_addr),
    .coef_data(coef_data), .clear(clear)
  );

  // Reference: scale by floor division (optionally after a half-LSB bias), clamp symmetrically.
  function automatic logic [15:0] scale_sat(input longint a, input int sh);
    longint v;
    v = a;
`ifdef CFIR_ROUND_EN
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
`endif
    v = v >>> sh;
    if (v > 32767) v = 32767;
    if (v < -32767) v = -32767;
    return v[15:0];
  endfunction

  task automatic model_accept(input logic [31:0] d);
    longint sr, si;
    hist_re.push_front(longint'($signed(d[15:0])));
    hist_im.push_front(longint'($signed(d[31:16])));
    if (hist_re.size() > NT) begin
      void'(hist_re.pop_back());
      void'(hist_im.pop_back());
    end
    sr = 0;
    si = 0;
    for (int k = 0; k < hist_re.size(); k++) begin
      sr += h_re[k] * hist_re[k] - h_im[k] * hist_im[k];
      si += h_re[k] * hist_im[k] + h_im[k] * hist_re[k];
    end
    exp0_q.push_back({scale_sat(si, 0), scale_sat(sr, 0)});
    exp1_q.push_back({scale_sat(si, 1), scale_sat(sr, 1)});
  endtask

  // All helpers start and end just after a falling edge.
  task automatic write_coef(input int k, input int re, input int im);
    coef_wr_en = 1'b1;
    coef_addr  = 2'(k);
    coef_data  = {16'(im), 16'(re)};
    h_re[k]    = longint'(re);
    h_im[k]    = longint'(im);
    @(negedge clk);
    coef_wr_en = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    s_tvalid = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    hist_re.delete();
    hist_im.delete();
  endtask

  task automatic set_impulse_coefs();
    for (int k = 0; k < NT; k++) write_coef(k, k + 1, 0);
    do_clear();
  endtask

  task automatic set_single_coef(input int re, input int im);
    write_coef(0, re, im);
    for (int k = 1; k < NT; k++) write_coef(k, 0, 0);
    do_clear();
  endtask

  // Sends (100,0) then four zeros; collects outputs and their latency in cycles.
  task automatic run_impulse();
    int sent;
    int acc_c[5];
    sent  = 0;
    imp_n = 0;
    m_tready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      s_tvalid = (sent < 5);
      s_tdata  = (sent == 0) ? {16'd0, 16'd100} : 32'd0;
      #1;
      if (s_tvalid && s_tready0) begin
        acc_c[sent] = c;
        sent++;
      end
      if (m_tvalid0 && imp_n < 8) begin
        imp_out[imp_n] = m_tdata0;
        imp_lat[imp_n] = (imp_n < 5) ? c - acc_c[imp_n] : -1;
        imp_n++;
      end
      @(negedge clk);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic run_single(input logic [31:0] d, output logic [31:0] o0,
                            output logic [31:0] o1, output bit got);
    bit sent;
    got  = 1'b0;
    sent = 1'b0;
    o0   = '0;
    o1   = '0;
    m_tready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      s_tvalid = !sent;
      s_tdata  = d;
      #1;
      if (s_tvalid && s_tready0) sent = 1'b1;
      if (m_tvalid0 && m_tvalid1 && !got) begin
        o0  = m_tdata0;
        o1  = m_tdata1;
        got = 1'b1;
      end
      @(negedge clk);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (m_tvalid0 !== 1'b0 || m_tdata0 !== 32'd0) begin
      n_err++;
      $display("FAIL reset_out: tvalid=%b tdata=%h, need 0/0", m_tvalid0, m_tdata0);
    end
    n_cmp++;
    if (s_tready0 !== 1'b0 || s_tready1 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_tready: got %b/%b, need 0", s_tready0, s_tready1);
    end
    rst = 1'b0;
    for (int k = 0; k < NT; k++) begin
      h_re[k] = 0;
      h_im[k] = 0;
    end
    #1;
    n_cmp++;
    if (s_tready0 !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_tready: got %b, need 1", s_tready0);
    end
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_impulse();
    int exp_v[5] = '{100, 200, 300, 400, 0};
    set_impulse_coefs();
    run_impulse();
    n_cmp++;
    if (imp_n !== 5) begin
      n_err++;
      $display("FAIL impulse_count: got %0d outputs, need 5", imp_n);
    end
    for (int i = 0; i < 5 && i < imp_n; i++) begin
      n_cmp++;
      if (imp_out[i] !== {16'd0, 16'(exp_v[i])}) begin
        n_err++;
        $display("FAIL impulse_y%0d: got %h, need %h", i, imp_out[i], {16'd0, 16'(exp_v[i])});
      end
    end
    n_cmp++;
    if (imp_n < 1 || imp_lat[0] !== 3) begin
      n_err++;
      $display("FAIL impulse_latency: got %0d cycles, need 3", (imp_n < 1) ? -1 : imp_lat[0]);
    end
    $display("test_impulse done: %0d outputs", imp_n);
  endtask

  task automatic test_cmul();
    logic [31:0] o0, o1;
    bit got;
    set_single_coef(0, 1);
    run_single({16'd4, 16'd3}, o0, o1, got);
    n_cmp++;
    if (!got || o0 !== {16'h0003, 16'hFFFC}) begin
      n_err++;
      $display("FAIL cmul: got %h (seen=%0b), need %h", o0, got, {16'h0003, 16'hFFFC});
    end
    $display("test_cmul: out=%h", o0);
  endtask

  task automatic test_saturation();
    logic [31:0] o0, o1;
    bit got;
    set_single_coef(32767, 0);
    run_single({16'hFFFE, 16'h0002}, o0, o1, got);
    n_cmp++;
    if (!got || o0 !== {16'h8001, 16'h7FFF}) begin
      n_err++;
      $display("FAIL sat_a: got %h (seen=%0b), need %h", o0, got, {16'h8001, 16'h7FFF});
    end
    do_clear();
    run_single({16'h7FFF, 16'h8000}, o0, o1, got);
    n_cmp++;
    if (!got || o0 !== {16'h7FFF, 16'h8001}) begin
      n_err++;
      $display("FAIL sat_b: got %h (seen=%0b), need %h", o0, got, {16'h7FFF, 16'h8001});
    end
    $display("test_saturation: out=%h", o0);
  endtask

  task automatic test_rounding();
    logic [31:0] o0, o1, e1;
    bit got;
`ifdef CFIR_ROUND_EN
    e1 = {16'hFFFF, 16'h0002};
`else
    e1 = {16'hFFFE, 16'h0001};
`endif
    set_single_coef(1, 0);
    run_single({16'hFFFD, 16'h0003}, o0, o1, got);
    n_cmp++;
    if (!got || o1 !== e1) begin
      n_err++;
      $display("FAIL round_shift1: got %h (seen=%0b), need %h", o1, got, e1);
    end
    n_cmp++;
    if (!got || o0 !== {16'hFFFD, 16'h0003}) begin
      n_err++;
      $display("FAIL round_shift0: got %h, need %h", o0, {16'hFFFD, 16'h0003});
    end
    $display("test_rounding: shift0=%h shift1=%h", o0, o1);
  endtask

  task automatic test_backpressure();
    int sent, recv, c;
    bit stalled;
    logic [31:0] held, e0, e1;
    for (int k = 0; k < NT; k++)
      write_coef(k, $signed(16'($urandom)), $signed(16'($urandom)));
    do_clear();
    exp0_q.delete();
    exp1_q.delete();
    sent = 0;
    recv = 0;
    stalled = 1'b0;
    held = '0;
    c = 0;
    while ((sent < 40 || recv < sent) && c < 400) begin
      if (stalled) begin
        n_cmp++;
        if (m_tvalid0 !== 1'b1 || m_tdata0 !== held) begin
          n_err++;
          $display("FAIL stall_hold: cycle %0d got %b/%h, need 1/%h", c, m_tvalid0, m_tdata0, held);
        end
      end
      s_tvalid = (sent < 40) && ($urandom_range(0, 3) != 0);
      s_tdata  = $urandom;
      m_tready = (c >= 20 && c < 25) ? 1'b0 : ($urandom_range(0, 4) != 0);
      #1;
      stalled = m_tvalid0 && !m_tready;
      held    = m_tdata0;
      if (stalled) begin
        n_cmp++;
        if (s_tready0 !== 1'b0) begin
          n_err++;
          $display("FAIL stall_tready: cycle %0d got %b, need 0", c, s_tready0);
        end
      end
      if (s_tvalid && s_tready0) begin
        model_accept(s_tdata);
        sent++;
      end
      if (m_tvalid0 && m_tready) begin
        e0 = (exp0_q.size() > 0) ? exp0_q.pop_front() : 32'hxxxxxxxx;
        e1 = (exp1_q.size() > 0) ? exp1_q.pop_front() : 32'hxxxxxxxx;
        n_cmp++;
        if (m_tdata0 !== e0 || m_tvalid1 !== 1'b1 || m_tdata1 !== e1) begin
          n_err++;
          $display("FAIL stream_y%0d: got %h/%h, need %h/%h", recv, m_tdata0, m_tdata1, e0, e1);
        end
        recv++;
      end
      @(negedge clk);
      c++;
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    n_cmp++;
    if (sent !== 40 || recv !== 40) begin
      n_err++;
      $display("FAIL stream_count: sent %0d recv %0d in %0d cycles, need 40/40", sent, recv, c);
    end
    $display("test_backpressure: sent %0d recv %0d cycles %0d", sent, recv, c);
  endtask

  task automatic test_clear();
    int nvalid;
    int exp_v[5] = '{100, 200, 300, 400, 0};
    set_impulse_coefs();
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = {16'($urandom_range(1, 1000)), 16'($urandom_range(1, 1000))};
      @(negedge clk);
    end
    do_clear();
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_tvalid0) nvalid++;
      @(negedge clk);
    end
    n_cmp++;
    if (nvalid !== 0) begin
      n_err++;
      $display("FAIL clear_flush: got %0d valid outputs, need 0", nvalid);
    end
    run_impulse();
    n_cmp++;
    if (imp_n !== 5) begin
      n_err++;
      $display("FAIL clear_impulse_count: got %0d, need 5", imp_n);
    end
    for (int i = 0; i < 5 && i < imp_n; i++) begin
      n_cmp++;
      if (imp_out[i] !== {16'd0, 16'(exp_v[i])}) begin
        n_err++;
        $display("FAIL clear_impulse_y%0d: got %h, need %h", i, imp_out[i], {16'd0, 16'(exp_v[i])});
      end
    end
    $display("test_clear: flushed, %0d impulse outputs", imp_n);
  endtask

  task automatic test_reset_midstream();
    int nz;
    set_impulse_coefs();
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = {16'd0, 16'd100};
      @(negedge clk);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (m_tvalid0 !== 1'b0 || m_tdata0 !== 32'd0 || s_tready0 !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid: tvalid=%b tdata=%h tready=%b, need 0/0/0", m_tvalid0, m_tdata0, s_tready0);
    end
    @(negedge clk);
    rst = 1'b0;
    s_tvalid = 1'b0;
    for (int k = 0; k < NT; k++) begin
      h_re[k] = 0;
      h_im[k] = 0;
    end
    @(negedge clk);
    run_impulse();
    nz = 0;
    for (int i = 0; i < imp_n; i++) if (imp_out[i] !== 32'd0) nz++;
    n_cmp++;
    if (imp_n !== 5 || nz !== 0) begin
      n_err++;
      $display("FAIL rst_coef_zero: got %0d outputs with %0d nonzero, need 5 with 0", imp_n, nz);
    end
    $display("test_reset_midstream: %0d outputs, %0d nonzero", imp_n, nz);
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_cmul();
    test_saturation();
    test_rounding();
    test_backpressure();
    test_clear();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
